// File: rtl/spi_flash_mem_ctrl_multi.sv
// SPI flash protocol engine: decodes host commands arriving on a 4-bit dq bus
// and turns them into byte-wide requests to a synchronous backing memory.
// Supports single/dual/quad reads, quad I/O read, status read, write-enable
// latch and page program with in-page address wrap.
//
// Host/memory handshake: a memory request is a single-cycle pulse on
// mem_req_valid. The memory samples the request at the next rising sck edge,
// and a read response is valid at the edge after that. Requests are decoded
// combinationally from the registered state, so a request tied to the last
// bit of an address or data byte can use that bit straight from dq_in.
// Requests are suppressed whenever cs is high.
module spi_flash_mem_ctrl_multi #(
  parameter int ADDR_BITS  = 24,
  parameter int ADDR_BYTES = 3,
  parameter int FAST_DUMMY = 8,
  parameter int QIO_DUMMY  = 6,
  parameter int PAGE_BITS  = 8
) (
  input  logic                 sck,
  input  logic                 reset,
  input  logic                 cs,
  input  logic [3:0]           dq_in,
  output logic [3:0]           dq_out,
  output logic [3:0]           dq_drive,
  output logic                 mem_req_valid,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [7:0]           mem_req_data,
  output logic                 mem_req_r_wb,
  input  logic [7:0]           mem_resp_data,
  output logic                 wel,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DUMMY  = 3'd3,
    S_DATA   = 3'd4,
    S_PROG   = 3'd5,
    S_IGNORE = 3'd6
  } state_e;

  // Lane width of the data phase
  localparam logic [1:0] LN1 = 2'd0;
  localparam logic [1:0] LN2 = 2'd1;
  localparam logic [1:0] LN4 = 2'd2;

  // Index of the last address edge for single-lane and quad-lane addresses
  localparam logic [7:0] ADDR_LAST_S  = 8'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0] ADDR_LAST_Q  = 8'(ADDR_BYTES * 2 - 1);
  localparam logic [7:0] FAST_DUMMY_C = 8'(FAST_DUMMY);
  localparam logic [7:0] QIO_DUMMY_C  = 8'(QIO_DUMMY);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [6:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           sh_q, sh_d;
  logic [3:0]           dq_out_q, dq_out_d;
  logic [3:0]           dq_drive_q, dq_drive_d;
  logic                 wel_q, wel_d;
  logic                 quad_addr_q, quad_addr_d;
  logic [7:0]           dummy_q, dummy_d;
  logic [1:0]           lanes_q, lanes_d;
  logic                 status_q, status_d;
  logic                 prog_q, prog_d;

  logic [7:0]           cmd_byte_c;
  logic [ADDR_BITS-1:0] addr_shift_c;
  logic [ADDR_BITS-1:0] addr_page_inc_c;
  logic                 addr_last_c;
  logic                 byte_last_c;
  logic [7:0]           src_c;

  // Helper decodes shared by the next-state logic
  always_comb begin
    cmd_byte_c   = {cmd_q, dq_in[0]};
    addr_shift_c = quad_addr_q ? {addr_q[ADDR_BITS-5:0], dq_in}
                               : {addr_q[ADDR_BITS-2:0], dq_in[0]};
    addr_page_inc_c = {addr_q[ADDR_BITS-1:PAGE_BITS],
                       addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
    addr_last_c  = quad_addr_q ? (cnt_q == ADDR_LAST_Q) : (cnt_q == ADDR_LAST_S);
    case (lanes_q)
      LN2:     byte_last_c = (cnt_q == 8'd3);
      LN4:     byte_last_c = (cnt_q == 8'd1);
      default: byte_last_c = (cnt_q == 8'd7);
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      cmd_q       <= 7'd0;
      addr_q      <= '0;
      sh_q        <= 8'd0;
      dq_out_q    <= 4'd0;
      dq_drive_q  <= 4'd0;
      wel_q       <= 1'b0;
      quad_addr_q <= 1'b0;
      dummy_q     <= 8'd0;
      lanes_q     <= LN1;
      status_q    <= 1'b0;
      prog_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      dq_out_q    <= dq_out_d;
      dq_drive_q  <= dq_drive_d;
      wel_q       <= wel_d;
      quad_addr_q <= quad_addr_d;
      dummy_q     <= dummy_d;
      lanes_q     <= lanes_d;
      status_q    <= status_d;
      prog_q      <= prog_d;
    end
  end

  // Next-state, shift-out and memory-request decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    sh_d          = sh_q;
    dq_out_d      = 4'd0;
    dq_drive_d    = 4'd0;
    wel_d         = wel_q;
    quad_addr_d   = quad_addr_q;
    dummy_d       = dummy_q;
    lanes_d       = lanes_q;
    status_d      = status_q;
    prog_d        = prog_q;
    src_c         = 8'd0;
    mem_req_valid = 1'b0;
    mem_req_r_wb  = 1'b1;
    mem_req_addr  = addr_q;
    mem_req_data  = 8'd0;

    if (cs) begin
      // Deselect ends any transaction; a program consumes the latch
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      if (prog_q) wel_d = 1'b0;
      prog_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // This edge carries the first opcode bit
          cmd_d       = {6'd0, dq_in[0]};
          cnt_d       = 8'd1;
          state_d     = S_CMD;
          status_d    = 1'b0;
          prog_d      = 1'b0;
          quad_addr_d = 1'b0;
          dummy_d     = 8'd0;
          lanes_d     = LN1;
        end
        S_CMD: begin
          if (cnt_q == 8'd7) begin
            cnt_d = 8'd0;
            case (cmd_byte_c)
              8'h06: begin wel_d = 1'b1; state_d = S_IGNORE; end
              8'h04: begin wel_d = 1'b0; state_d = S_IGNORE; end
              8'h05: begin status_d = 1'b1; lanes_d = LN1; state_d = S_DATA; end
              8'h03: state_d = S_ADDR;
              8'h0B: begin dummy_d = FAST_DUMMY_C; state_d = S_ADDR; end
              8'h3B: begin dummy_d = FAST_DUMMY_C; lanes_d = LN2; state_d = S_ADDR; end
              8'h6B: begin dummy_d = FAST_DUMMY_C; lanes_d = LN4; state_d = S_ADDR; end
              8'hEB: begin
                dummy_d     = QIO_DUMMY_C;
                lanes_d     = LN4;
                quad_addr_d = 1'b1;
                state_d     = S_ADDR;
              end
              8'h02: begin
                if (wel_q) begin
                  prog_d  = 1'b1;
                  state_d = S_ADDR;
                end else begin
                  state_d = S_IGNORE;
                end
              end
              default: state_d = S_IGNORE;
            endcase
          end else begin
            cmd_d = {cmd_q[5:0], dq_in[0]};
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_ADDR: begin
          addr_d = addr_shift_c;
          cnt_d  = cnt_q + 8'd1;
          if (addr_last_c) begin
            cnt_d = 8'd0;
            if (prog_q) begin
              state_d = S_PROG;
            end else if (dummy_q == 8'd0) begin
              // No dummy: fetch the first byte with the final address bits
              mem_req_valid = 1'b1;
              mem_req_addr  = addr_shift_c;
              addr_d        = addr_shift_c + ADDR_BITS'(1);
              state_d       = S_DATA;
            end else begin
              state_d = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == dummy_q - 8'd1) begin
            mem_req_valid = 1'b1;
            addr_d        = addr_q + ADDR_BITS'(1);
            cnt_d         = 8'd0;
            state_d       = S_DATA;
          end
        end
        S_DATA: begin
          // First edge of a byte loads the fresh memory/status byte
          if (cnt_q == 8'd0) src_c = status_q ? {6'd0, wel_q, 1'b0} : mem_resp_data;
          else               src_c = sh_q;
          case (lanes_q)
            LN2: begin
              dq_out_d   = {2'b00, src_c[7:6]};
              dq_drive_d = 4'b0011;
              sh_d       = src_c << 2;
            end
            LN4: begin
              dq_out_d   = src_c[7:4];
              dq_drive_d = 4'b1111;
              sh_d       = src_c << 4;
            end
            default: begin
              dq_out_d   = {2'b00, src_c[7], 1'b0};
              dq_drive_d = 4'b0010;
              sh_d       = src_c << 1;
            end
          endcase
          if (byte_last_c) begin
            cnt_d = 8'd0;
            // Fetch the next byte so it lands on the next byte's first edge
            if (!status_q) begin
              mem_req_valid = 1'b1;
              addr_d        = addr_q + ADDR_BITS'(1);
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_PROG: begin
          sh_d  = {sh_q[6:0], dq_in[0]};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            // Byte completes on this edge: write it, advance within the page
            mem_req_valid = 1'b1;
            mem_req_r_wb  = 1'b0;
            mem_req_data  = {sh_q[6:0], dq_in[0]};
            addr_d        = addr_page_inc_c;
            cnt_d         = 8'd0;
          end
        end
        S_IGNORE: begin
          cnt_d = cnt_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dq_out    = dq_out_q;
  assign dq_drive  = dq_drive_q;
  assign wel       = wel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_flash_mem_ctrl_multi.sv
// Bench for spi_flash_mem_ctrl_multi: host-side SPI driver tasks, a sparse
// byte memory model, and scoreboards for read data and memory writes.
module tb_spi_flash_mem_ctrl_multi;

  logic        sck;
  logic        reset;
  logic        cs;
  logic [3:0]  dq_in;
  logic [3:0]  dq_out;
  logic [3:0]  dq_drive;
  logic        mem_req_valid;
  logic [23:0] mem_req_addr;
  logic [7:0]  mem_req_data;
  logic        mem_req_r_wb;
  logic [7:0]  mem_resp_data;
  logic        wel;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int rd_req_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] wr_exp_q[$];
  logic [7:0]  mem [logic [23:0]];

  spi_flash_mem_ctrl_multi #(
    .ADDR_BITS(24), .ADDR_BYTES(3), .FAST_DUMMY(8), .QIO_DUMMY(6), .PAGE_BITS(8)
  ) dut (
    .sck(sck), .reset(reset), .cs(cs), .dq_in(dq_in),
    .dq_out(dq_out), .dq_drive(dq_drive),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_r_wb(mem_req_r_wb),
    .mem_resp_data(mem_resp_data), .wel(wel), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    sck = 1'b0;
    forever #5 sck = ~sck;
  end

  // Synchronous memory model; writes are checked against the write scoreboard
  always @(posedge sck) begin
    if (mem_req_valid) begin
      if (mem_req_r_wb) begin
        rd_req_cnt++;
        mem_resp_data <= mem.exists(mem_req_addr) ? mem[mem_req_addr] : 8'h00;
      end else begin
        checks++;
        if (wr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%06h data=%02h, required no write",
                   mem_req_addr, mem_req_data);
        end else begin
          logic [31:0] e;
          e = wr_exp_q.pop_front();
          if ({8'h00, mem_req_addr, mem_req_data} !== e) begin
            errors++;
            $display("FAIL write: got addr=%06h data=%02h, required addr=%06h data=%02h",
                     mem_req_addr, mem_req_data, e[31:8], e[7:0]);
          end
        end
        mem[mem_req_addr] = mem_req_data;
      end
    end
  end

  // Driver tasks: start and end on a falling edge; DUT samples in between
  task automatic spi_edge(input logic [3:0] v);
    cs = 1'b0;
    dq_in = v;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    dq_in = 4'h0;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_edge({3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    if (quad) for (int i = 5; i >= 0; i--) spi_edge(a[i*4 +: 4]);
    else      for (int i = 23; i >= 0; i--) spi_edge({3'b000, a[i]});
  endtask

  task automatic dummy_edges(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      spi_edge(4'h0);
      checks++;
      if (dq_drive !== 4'h0) begin
        errors++;
        $display("FAIL %s_dummy_drive: got %b, required 0000", name, dq_drive);
      end
    end
  endtask

  // Collect nbytes from the data phase and compare with the expected queue
  task automatic read_data(input int lanes, input int nbytes, input string name);
    logic [7:0] val;
    logic [7:0] e;
    logic [3:0] mask;
    int edges;
    edges = 8 / lanes;
    mask = (lanes == 1) ? 4'b0010 : (lanes == 2) ? 4'b0011 : 4'b1111;
    for (int b = 0; b < nbytes; b++) begin
      val = 8'h00;
      for (int k = 0; k < edges; k++) begin
        spi_edge(4'h0);
        if (k == 0) begin
          checks++;
          if (dq_drive !== mask) begin
            errors++;
            $display("FAIL %s_drive: got %b, required %b", name, dq_drive, mask);
          end
        end
        case (lanes)
          1:       val = {val[6:0], dq_out[1]};
          2:       val = {val[5:0], dq_out[1:0]};
          default: val = {val[3:0], dq_out};
        endcase
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_data: got %02h, required nothing queued", name, val);
      end else begin
        e = exp_q.pop_front();
        if (val !== e) begin
          errors++;
          $display("FAIL %s_data: got %02h, required %02h", name, val, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (dq_drive !== 4'h0 || dq_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_dq: got drive=%b out=%h, required 0/0", dq_drive, dq_out);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_r_wb !== 1'b1) begin
      errors++;
      $display("FAIL reset_req: got valid=%b r_wb=%b, required 0/1", mem_req_valid, mem_req_r_wb);
    end
    checks++;
    if (wel !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got wel=%b state=%0d, required 0/0", wel, dbg_state);
    end
  endtask

  task automatic test_read();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    send_byte(8'h03);
    send_addr(24'h000010, 1'b0);
    read_data(1, 2, "read03");
    cs_high();
  endtask

  task automatic test_fast_read();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'h30 + i));
    send_byte(8'h0B);
    send_addr(24'h000030, 1'b0);
    dummy_edges(8, "fast0b");
    read_data(1, 3, "fast0b");
    cs_high();
  endtask

  task automatic test_dual_read();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h41);
    send_byte(8'h3B);
    send_addr(24'h000040, 1'b0);
    dummy_edges(8, "dual3b");
    read_data(2, 2, "dual3b");
    cs_high();
  endtask

  task automatic test_quad_read();
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    send_byte(8'h6B);
    send_addr(24'h000020, 1'b0);
    dummy_edges(8, "quad6b");
    read_data(4, 2, "quad6b");
    cs_high();
  endtask

  task automatic test_qio_wrap();
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    send_byte(8'hEB);
    send_addr(24'hFFFFFF, 1'b1);
    dummy_edges(6, "qioeb");
    read_data(4, 3, "qioeb");
    cs_high();
  endtask

  task automatic test_wel();
    send_byte(8'h06);
    cs_high();
    checks++;
    if (wel !== 1'b1) begin
      errors++;
      $display("FAIL wel_set: got %b, required 1", wel);
    end
    send_byte(8'h04);
    cs_high();
    checks++;
    if (wel !== 1'b0) begin
      errors++;
      $display("FAIL wel_clear: got %b, required 0", wel);
    end
  endtask

  task automatic test_program();
    // Rejected program: latch clear, so no write may appear
    send_byte(8'h02);
    send_addr(24'h000080, 1'b0);
    send_byte(8'h5A);
    checks++;
    if (dq_drive !== 4'h0) begin
      errors++;
      $display("FAIL prog_reject_drive: got %b, required 0000", dq_drive);
    end
    cs_high();
    send_byte(8'h06);
    cs_high();
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    send_byte(8'h05);
    read_data(1, 2, "rdsr");
    cs_high();
    wr_exp_q.push_back({8'h00, 24'h0000FF, 8'h11});
    wr_exp_q.push_back({8'h00, 24'h000000, 8'h22});
    send_byte(8'h02);
    send_addr(24'h0000FF, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    cs_high();
    checks++;
    if (wel !== 1'b0) begin
      errors++;
      $display("FAIL prog_wel_after: got %b, required 0", wel);
    end
    checks++;
    if (wr_exp_q.size() != 0) begin
      errors++;
      $display("FAIL prog_writes: got %0d writes missing, required 0", wr_exp_q.size());
    end
    exp_q.push_back(8'h11);
    send_byte(8'h03);
    send_addr(24'h0000FF, 1'b0);
    read_data(1, 1, "prog_rb_ff");
    cs_high();
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h01);
    send_byte(8'h03);
    send_addr(24'h000000, 1'b0);
    read_data(1, 2, "prog_rb_00");
    cs_high();
  endtask

  task automatic test_abort_program();
    send_byte(8'h06);
    cs_high();
    send_byte(8'h02);
    send_addr(24'h000050, 1'b0);
    for (int i = 0; i < 4; i++) spi_edge(4'h1);
    cs_high();
    checks++;
    if (wel !== 1'b0) begin
      errors++;
      $display("FAIL abort_wel: got %b, required 0", wel);
    end
    exp_q.push_back(8'h50);
    send_byte(8'h03);
    send_addr(24'h000050, 1'b0);
    read_data(1, 1, "abort_rb");
    cs_high();
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(8'h20);
    send_byte(8'h6B);
    send_addr(24'h000020, 1'b0);
    dummy_edges(8, "rstmid");
    read_data(4, 1, "rstmid");
    spi_edge(4'h0);
    reset = 1'b0;
    #1;
    checks++;
    if (dq_drive !== 4'h0 || dq_out !== 4'h0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got drive=%b out=%h valid=%b, required 0/0/0",
               dq_drive, dq_out, mem_req_valid);
    end
    cs = 1'b1;
    @(negedge sck);
    reset = 1'b1;
    cs_high();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
    send_byte(8'h03);
    send_addr(24'h000005, 1'b0);
    read_data(1, 2, "after_reset");
    cs_high();
  endtask

  task automatic test_unknown();
    int rd_before;
    int bad_edges;
    rd_before = rd_req_cnt;
    bad_edges = 0;
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) begin
      spi_edge(4'($urandom_range(0, 15)));
      if (dq_drive !== 4'h0) bad_edges++;
    end
    cs_high();
    checks++;
    if (bad_edges != 0) begin
      errors++;
      $display("FAIL unknown_drive: got %0d driven edges, required 0", bad_edges);
    end
    checks++;
    if (rd_req_cnt != rd_before) begin
      errors++;
      $display("FAIL unknown_req: got %0d reads, required 0", rd_req_cnt - rd_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    for (int t = 0; t < 3; t++) begin
      a = 24'($urandom_range(0, 250));
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(a + 24'(i)));
      send_byte(8'h6B);
      send_addr(a, 1'b0);
      dummy_edges(8, "b2b");
      read_data(4, 4, "b2b");
      cs_high();
    end
  endtask

  initial begin
    reset = 1'b0;
    cs = 1'b1;
    dq_in = 4'h0;
    mem_resp_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[24'(i)] = 8'(i);
    mem[24'hFFFFFF] = 8'hAB;
    repeat (3) @(negedge sck);
    test_reset();
    reset = 1'b1;
    cs_high();
    test_read();
    test_fast_read();
    test_dual_read();
    test_quad_read();
    test_qio_wrap();
    test_wel();
    test_program();
    test_abort_program();
    test_reset_mid();
    test_unknown();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0 || wr_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d reads/%0d writes pending, required 0/0",
               exp_q.size(), wr_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_mem_ctrl_multi.md
Name: spi_flash_mem_ctrl_multi

Overview:
Next-generation SPI flash protocol engine for the simulated flash model. It decodes SPI commands from a host over a 4-bit dq bus and issues byte-wide requests to a synchronous backing memory. Over the single-mode controller it adds configurable address bytes and dummy cycles, dual/quad output reads, quad I/O read, a write-enable latch, status read and page program.

Parameters:
ADDR_BITS, 24, backing-memory address width (bytes)
ADDR_BYTES, 3, address bytes per command (3 or 4); the low ADDR_BITS of the received address are used
FAST_DUMMY, 8, dummy cycles for 0x0B/0x3B/0x6B
QIO_DUMMY, 6, dummy cycles for 0xEB
PAGE_BITS, 8, program wrap granule (page = 2^PAGE_BITS bytes)

Ports:
sck  in  1  SPI clock; the sole clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cs  in  1  chip select, active low, sampled on sck rising edge
dq_in  in  4  sampled bus
dq_out  out  4  drive values
dq_drive  out  4  per-lane output enables
mem_req_valid  out  1  memory request this cycle
mem_req_addr  out  ADDR_BITS  request address
mem_req_data  out  8  write data
mem_req_r_wb  out  1  1=read, 0=write
mem_resp_data  in  8  read data, valid at the sck edge after the request edge
wel  out  1  write-enable latch (status bit 1)

Behaviour:
- Reset (reset=0, any time): FSM=IDLE, wel=0, dq_drive=0, dq_out=0, mem_req_valid=0, mem_req_r_wb=1, address/data regs=0.
- At any edge with cs=1: FSM->IDLE, dq_drive=0, no mem request. If the last command was program, wel->0. The host supplies at least one sck edge with cs=1 between transactions.
- Command phase: 8 bits on dq_in[0], MSB first, one per edge.
- 0x06 sets wel and 0x04 clears wel, at the 8th command edge.
- 0x05 (RDSR): status {6'b0, wel, 1'b0} shifts out on dq[1], MSB first, repeating until cs=1.
- 0x03 READ: ADDR_BYTES*8 address bits on dq[0], no dummy.
- 0x0B: as 0x03, then FAST_DUMMY cycles.
- 0x3B: single-lane address, FAST_DUMMY cycles, data on dq[1:0], 2 bits/edge.
- 0x6B: single-lane address, FAST_DUMMY cycles, data on dq[3:0].
- 0xEB: address on dq[3:0] (ADDR_BYTES*2 edges), QIO_DUMMY cycles, data on dq[3:0].
- Read data timing:
  - First data bits are driven by the edge after the last address/dummy edge; the host samples them on the next edge.
  - Byte order MSB first; upper nibble/pair/bit first.
  - mem read issued with r_wb=1 early enough that each byte is ready when its first bits shift out.
  - Address increments per byte and wraps from 2^ADDR_BITS-1 to 0.
  - Continues until cs=1.
- dq_drive during data phase: 4'b0010 single, 4'b0011 dual, 4'b1111 quad; 0 in every other phase.
- 0x02 PAGE PROGRAM: requires wel=1 at the command's 8th edge, else FSM->IGNORE.
  - Address on dq[0], then data bytes on dq[0].
  - Each completed byte gives one mem_req_valid cycle with r_wb=0 and the current address.
  - Address low PAGE_BITS increment and wrap within the page; upper bits stay fixed.
  - A partial byte at cs=1 is discarded.
- Unknown opcode -> IGNORE: no drive and no requests until cs=1.
- mem_req_valid is high for exactly one cycle per request; never for reads and writes in the same cycle.
- cs=1 mid-address, mid-dummy or mid-byte aborts with no write and no further requests.

Test Plan:
- Memory preloaded 0x00..0xFF at addr 0. Send 0x03, addr 0x000010, 16 edges -> dq[1] serialises 0x10 then 0x11; dq_drive=4'b0010; ADDR_BITS=24 wrap unexercised.
- 0x6B at addr 0x000020 with FAST_DUMMY=8 -> 8 dummy edges with dq_drive=0, then nibbles 2,0,2,1 on dq[3:0]; dq_drive=4'b1111.
- 0xEB at addr 0xFFFFFF (mem holds 0xAB at top, 0x00 at 0) -> QIO_DUMMY=6 edges, then 0xAB followed by 0x00 (address wrap).
- 0x02 without prior 0x06 -> no mem_req_valid. Then 0x06, 0x05 -> status reads 0x02. Then 0x02 at addr 0x0000FF with data 0x11,0x22 -> writes 0xFF<=0x11 and 0x00<=0x22 (page wrap). After cs=1, wel=0.
- cs=1 after 4 data bits of a program byte -> no write for that byte; the next 0x03 reads old data.
- reset pulled low mid-0x6B data -> all outputs 0 immediately; after release, a fresh 0x03 works normally. Opcode 0x9F -> dq_drive stays 0 until cs=1.
